// File: rtl/div_pkg.sv
// Shared types and constants for the two-port divider arbiter.
//   state_e      : arbiter FSM states
//   err_t        : response error code
//   ERR_*        : error code values
//   DVD_W/DVS_W  : dividend / divisor (and quotient / remainder) widths
//   launch_check : pre-launch operand screening shared by grant and LAUNCH
package div_pkg;

    localparam int unsigned DVD_W = 10;
    localparam int unsigned DVS_W = 5;

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

    typedef logic [1:0] err_t;

    localparam err_t ERR_OK      = 2'b00;
    localparam err_t ERR_DIV0    = 2'b01;
    localparam err_t ERR_OVF     = 2'b10;
    localparam err_t ERR_TIMEOUT = 2'b11;

    // The quotient fits in DVS_W bits only when the dividend's upper half is
    // strictly below the divisor; zero divisor has priority over overflow.
    function automatic err_t launch_check(input logic [DVD_W-1:0] dvd,
                                          input logic [DVS_W-1:0] dvs);
        if (dvs == '0) begin
            return ERR_DIV0;
        end
        if (dvd[DVD_W-1 -: DVS_W] >= dvs) begin
            return ERR_OVF;
        end
        return ERR_OK;
    endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared divider.
//   req0/1, dividend0/1, divisor0/1 : requester side requests and operands
//   ack0/1, Q, R, err               : per-requester response
//   div_start, div_dividend/divisor : launch to the shared divider
//   div_Q, div_R, div_ready         : divider results and idle/done flag
// Modports: master = arbiter view, slave = environment (requesters + divider).
interface div_arbiter_if;
    import div_pkg::*;

    logic             req0;
    logic             req1;
    logic [DVD_W-1:0] dividend0;
    logic [DVD_W-1:0] dividend1;
    logic [DVS_W-1:0] divisor0;
    logic [DVS_W-1:0] divisor1;
    logic             ack0;
    logic             ack1;
    logic [DVS_W-1:0] Q;
    logic [DVS_W-1:0] R;
    err_t             err;
    logic             div_start;
    logic [DVD_W-1:0] div_dividend;
    logic [DVS_W-1:0] div_divisor;
    logic [DVS_W-1:0] div_Q;
    logic [DVS_W-1:0] div_R;
    logic             div_ready;

    modport master (
        input  req0, req1, dividend0, dividend1, divisor0, divisor1,
        input  div_Q, div_R, div_ready,
        output ack0, ack1, Q, R, err,
        output div_start, div_dividend, div_divisor
    );

    modport slave (
        output req0, req1, dividend0, dividend1, divisor0, divisor1,
        output div_Q, div_R, div_ready,
        input  ack0, ack1, Q, R, err,
        input  div_start, div_dividend, div_divisor
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick.
//   req0, req1 : pending requests
//   last_grant : port granted most recently
//   valid      : at least one request pending
//   pick       : chosen port (0 or 1); on a tie, the port not granted last
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic pick
);

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else begin
            pick = req1;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Two-port round-robin arbiter in front of one shared restoring divider.
// Screens operands (divide-by-zero, quotient overflow), launches the divider,
// waits for completion under a watchdog and returns Q/R/err with a one-cycle
// ack to the granted port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : div_arbiter_if.master (requesters + divider signals)
//   TIMEOUT  : maximum WAIT cycles before the job is aborted with ERR_TIMEOUT
module div_arbiter
    import div_pkg::*;
#(
    parameter int unsigned TIMEOUT = 40
) (
    input logic          clk,
    input logic          rst,
    div_arbiter_if.master bus
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e           state;
    logic             last_grant;
    logic             port;
    logic             busy_seen;
    logic [WD_W-1:0]  wdog;
    logic             ack0;
    logic             ack1;
    logic             div_start;
    logic [DVS_W-1:0] q;
    logic [DVS_W-1:0] r;
    err_t             err;
    logic [DVD_W-1:0] dvd;
    logic [DVS_W-1:0] dvs;

    logic             pick_valid;
    logic             pick;
    logic [DVD_W-1:0] sel_dvd;
    logic [DVS_W-1:0] sel_dvs;
    err_t             chk;

    rr_pick2 u_pick (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .pick       (pick)
    );

    assign sel_dvd = pick ? bus.dividend1 : bus.dividend0;
    assign sel_dvs = pick ? bus.divisor1  : bus.divisor0;
    assign chk     = launch_check(dvd, dvs);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            last_grant <= 1'b1;
            port       <= 1'b0;
            busy_seen  <= 1'b0;
            wdog       <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            div_start  <= 1'b0;
            q          <= '0;
            r          <= '0;
            err        <= ERR_OK;
            dvd        <= '0;
            dvs        <= '0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            div_start <= 1'b0;
            case (state)
                StIdle: begin
                    if (pick_valid) begin
                        port       <= pick;
                        last_grant <= pick;
                        dvd        <= sel_dvd;
                        dvs        <= sel_dvs;
                        // Registered start must already be high during LAUNCH,
                        // so screen the operands being latched right now.
                        div_start  <= (launch_check(sel_dvd, sel_dvs) == ERR_OK);
                        state      <= StLaunch;
                    end
                end
                StLaunch: begin
                    if (chk != ERR_OK) begin
                        err   <= chk;
                        ack0  <= ~port;
                        ack1  <= port;
                        state <= StResp;
                    end else begin
                        busy_seen <= 1'b0;
                        wdog      <= '0;
                        state     <= StWait;
                    end
                end
                StWait: begin
                    if (!bus.div_ready) begin
                        busy_seen <= 1'b1;
                    end
                    // Ready alone may be the stale idle level; require a busy phase first.
                    if (bus.div_ready && busy_seen) begin
                        q     <= bus.div_Q;
                        r     <= bus.div_R;
                        err   <= ERR_OK;
                        ack0  <= ~port;
                        ack1  <= port;
                        state <= StResp;
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        err   <= ERR_TIMEOUT;
                        ack0  <= ~port;
                        ack1  <= port;
                        state <= StResp;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                StResp: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.ack0         = ack0;
    assign bus.ack1         = ack1;
    assign bus.Q            = q;
    assign bus.R            = r;
    assign bus.err          = err;
    assign bus.div_start    = div_start;
    assign bus.div_dividend = dvd;
    assign bus.div_divisor  = dvs;

endmodule

// File: tb/tb_div_arbiter.sv
`timescale 1ns/1ps
module tb_div_arbiter;
    import div_pkg::*;

    localparam int unsigned TIMEOUT = 40;
    localparam int NJOBS = 80;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_arbiter_if bus ();

    div_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int both_ack_cnt = 0;
    bit stuck = 1'b0;
    int busy_len = 3;

    // Reference model state: what Q/R should show, and the round-robin memory.
    logic [4:0] exp_q;
    logic [4:0] exp_r;
    bit         model_last;

    // Behavioural divider: busy for busy_len cycles after a start, or, when
    // stuck, ignores starts and never leaves the ready level.
    int         busy_cnt = 0;
    logic [9:0] m_a;
    logic [4:0] m_b;
    always @(posedge clk) begin
        if (bus.div_start === 1'b1 && !stuck) begin
            busy_cnt      <= busy_len;
            bus.div_ready <= 1'b0;
            m_a           <= bus.div_dividend;
            m_b           <= bus.div_divisor;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            if (busy_cnt == 1) begin
                bus.div_Q <= 5'(int'(m_a) / int'(m_b));
                bus.div_R <= 5'(int'(m_a) % int'(m_b));
            end
            busy_cnt      <= 0;
            bus.div_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (bus.div_start === 1'b1) start_cnt <= start_cnt + 1;
        if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) both_ack_cnt <= both_ack_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not end, required end before 5ms");
        $fatal(1);
    end

    function automatic logic [1:0] ref_err(input int a, input int b);
        if (b == 0) return 2'b01;
        if (a / 32 >= b) return 2'b10;
        return 2'b00;
    endfunction

    task automatic set_op(input int p, input int a, input int b);
        if (p == 0) begin
            bus.dividend0 = 10'(a);
            bus.divisor0  = 5'(b);
            bus.req0      = 1'b1;
        end else begin
            bus.dividend1 = 10'(a);
            bus.divisor1  = 5'(b);
            bus.req1      = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges from the first one that samples the request until an ack.
    task automatic wait_ack(input int limit, output int edges, output bit got, output bit p);
        edges = 0;
        got   = 1'b0;
        p     = 1'b0;
        while (!got && edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
                got = 1'b1;
                p   = bus.ack1;
            end
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        idle(2);
        rst        = 1'b0;
        exp_q      = '0;
        exp_r      = '0;
        model_last = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.ack0, bus.ack1, bus.div_start, bus.Q, bus.R, bus.err,
             bus.div_dividend, bus.div_divisor} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack0=%b ack1=%b start=%b Q=%0d R=%0d err=%b dvd=%0d dvs=%0d, required all 0",
                     bus.ack0, bus.ack1, bus.div_start, bus.Q, bus.R, bus.err,
                     bus.div_dividend, bus.div_divisor);
        end
        idle(3);
        checks++;
        if ({bus.ack0, bus.ack1, bus.div_start} !== 3'b000 || start_cnt != 0) begin
            errors++;
            $display("FAIL idle_quiet: got ack0=%b ack1=%b start=%b starts=%0d, required 0",
                     bus.ack0, bus.ack1, bus.div_start, start_cnt);
        end
    endtask

    task automatic test_single();
        int e; bit got; bit p; int s0;
        s0 = start_cnt;
        busy_len = 4;
        set_op(0, 100, 7);
        wait_ack(100, e, got, p);
        bus.req0 = 1'b0;
        checks++;
        if (!got || p !== 1'b0) begin
            errors++;
            $display("FAIL single_port: got ack=%b port=%0d, required ack on port 0", got, p);
        end
        checks++;
        if (bus.Q !== 5'd14 || bus.R !== 5'd2 || bus.err !== ERR_OK) begin
            errors++;
            $display("FAIL single_result: got Q=%0d R=%0d err=%b, required Q=14 R=2 err=00",
                     bus.Q, bus.R, bus.err);
        end
        idle(3);
        checks++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL single_starts: got %0d div_start pulses, required 1", start_cnt - s0);
        end
        exp_q = 5'd14; exp_r = 5'd2; model_last = 1'b0;
    endtask

    task automatic test_back_to_back();
        int e1; int e2; bit g1; bit g2; bit p1; bit p2; int s0;
        do_reset();
        s0 = start_cnt;
        busy_len = 3;
        set_op(0, 300, 20);
        set_op(1, 50, 3);
        wait_ack(100, e1, g1, p1);
        bus.req0 = 1'b0;
        checks++;
        if (!g1 || p1 !== 1'b0 || bus.Q !== 5'd15 || bus.R !== 5'd0 || bus.err !== ERR_OK) begin
            errors++;
            $display("FAIL tie_first: got ack=%b port=%0d Q=%0d R=%0d err=%b, required port 0 Q=15 R=0 err=00",
                     g1, p1, bus.Q, bus.R, bus.err);
        end
        wait_ack(100, e2, g2, p2);
        bus.req1 = 1'b0;
        checks++;
        if (!g2 || p2 !== 1'b1 || bus.Q !== 5'd16 || bus.R !== 5'd2 || bus.err !== ERR_OK) begin
            errors++;
            $display("FAIL tie_second: got ack=%b port=%0d Q=%0d R=%0d err=%b, required port 1 Q=16 R=2 err=00",
                     g2, p2, bus.Q, bus.R, bus.err);
        end
        checks++;
        if (e2 != e1 + 1) begin
            errors++;
            $display("FAIL tie_spacing: got %0d cycles between acks, required %0d", e2, e1 + 1);
        end
        idle(2);
        checks++;
        if (start_cnt - s0 != 2) begin
            errors++;
            $display("FAIL tie_starts: got %0d div_start pulses, required 2", start_cnt - s0);
        end
        exp_q = 5'd16; exp_r = 5'd2; model_last = 1'b1;
    endtask

    task automatic test_div_zero();
        int e; bit got; bit p; int s0;
        s0 = start_cnt;
        set_op(1, 55, 0);
        wait_ack(20, e, got, p);
        bus.req1 = 1'b0;
        checks++;
        if (!got || p !== 1'b1 || e != 2) begin
            errors++;
            $display("FAIL div0_latency: got ack=%b port=%0d after %0d edges, required port 1 after 2",
                     got, p, e);
        end
        checks++;
        if (bus.err !== ERR_DIV0 || bus.Q !== exp_q || bus.R !== exp_r) begin
            errors++;
            $display("FAIL div0_result: got err=%b Q=%0d R=%0d, required err=01 Q=%0d R=%0d",
                     bus.err, bus.Q, bus.R, exp_q, exp_r);
        end
        idle(1);
        checks++;
        if (start_cnt != s0) begin
            errors++;
            $display("FAIL div0_start: got %0d div_start pulses, required 0", start_cnt - s0);
        end
        model_last = 1'b1;
    endtask

    task automatic test_overflow();
        int e; bit got; bit p; int s0;
        int dv[2] = '{5, 31};
        s0 = start_cnt;
        foreach (dv[i]) begin
            set_op(0, 1000, dv[i]);
            wait_ack(20, e, got, p);
            bus.req0 = 1'b0;
            checks++;
            if (!got || p !== 1'b0 || e != 2 || bus.err !== ERR_OVF
                || bus.Q !== exp_q || bus.R !== exp_r) begin
                errors++;
                $display("FAIL ovf_1000_%0d: got ack=%b port=%0d edges=%0d err=%b Q=%0d R=%0d, required port 0 edges=2 err=10 Q=%0d R=%0d",
                         dv[i], got, p, e, bus.err, bus.Q, bus.R, exp_q, exp_r);
            end
            idle(1);
        end
        checks++;
        if (start_cnt != s0) begin
            errors++;
            $display("FAIL ovf_start: got %0d div_start pulses, required 0", start_cnt - s0);
        end
        model_last = 1'b0;
    endtask

    task automatic test_timeout();
        int e; bit got; bit p; int s0;
        s0 = start_cnt;
        stuck = 1'b1;
        set_op(0, 100, 7);
        wait_ack(TIMEOUT + 20, e, got, p);
        bus.req0 = 1'b0;
        checks++;
        if (!got || p !== 1'b0 || e != int'(TIMEOUT) + 2) begin
            errors++;
            $display("FAIL timeout_latency: got ack=%b port=%0d after %0d edges, required port 0 after %0d",
                     got, p, e, TIMEOUT + 2);
        end
        checks++;
        if (bus.err !== ERR_TIMEOUT || bus.Q !== exp_q || bus.R !== exp_r) begin
            errors++;
            $display("FAIL timeout_result: got err=%b Q=%0d R=%0d, required err=11 Q=%0d R=%0d",
                     bus.err, bus.Q, bus.R, exp_q, exp_r);
        end
        idle(1);
        stuck = 1'b0;
        checks++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL timeout_starts: got %0d div_start pulses, required 1", start_cnt - s0);
        end
        model_last = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int e; bit got; bit p; int n; int acks;
        busy_len = 12;
        set_op(0, 100, 7);
        n = 0;
        while (bus.div_start !== 1'b1 && n < 10) begin
            idle(1);
            n++;
        end
        idle(3);
        rst = 1'b1;
        bus.req0 = 1'b0;
        idle(1);
        rst = 1'b0;
        exp_q = '0; exp_r = '0; model_last = 1'b1;
        acks = 0;
        repeat (16) begin
            idle(1);
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL abort_no_ack: got %0d acks after reset, required 0", acks);
        end
        checks++;
        if ({bus.Q, bus.R, bus.err, bus.div_dividend, bus.div_divisor} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got Q=%0d R=%0d err=%b dvd=%0d dvs=%0d, required all 0",
                     bus.Q, bus.R, bus.err, bus.div_dividend, bus.div_divisor);
        end
        busy_len = 2;
        set_op(1, 200, 9);
        wait_ack(100, e, got, p);
        bus.req1 = 1'b0;
        checks++;
        if (!got || p !== 1'b1 || bus.Q !== 5'd22 || bus.R !== 5'd2 || bus.err !== ERR_OK) begin
            errors++;
            $display("FAIL after_abort: got ack=%b port=%0d Q=%0d R=%0d err=%b, required port 1 Q=22 R=2 err=00",
                     got, p, bus.Q, bus.R, bus.err);
        end
        idle(2);
        exp_q = 5'd22; exp_r = 5'd2; model_last = 1'b1;
    endtask

    // Random traffic on both ports against a queue-free job model: each port
    // holds at most one pending job; grants follow round-robin at free edges.
    task automatic test_random();
        bit pend[2];
        int pa[2];
        int pb[2];
        bit model_idle = 1'b1;
        bit free_next  = 1'b0;
        bit in_job     = 1'b0;
        bit exp_port   = 1'b0;
        int ja = 0; int jb = 1;
        int done = 0; int ok_jobs = 0; int s0; int age = 0;
        logic [1:0] e;
        pend[0] = 1'b0; pend[1] = 1'b0;
        s0 = start_cnt;
        for (int cyc = 0; cyc < 20000 && done < NJOBS; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 3) == 0) begin
                    pa[p] = int'($urandom_range(0, 1023));
                    pb[p] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31));
                    pend[p] = 1'b1;
                    set_op(p, pa[p], pb[p]);
                end
            end
            busy_len = int'($urandom_range(1, 6));
            if (model_idle && (pend[0] || pend[1])) begin
                exp_port   = (pend[0] && pend[1]) ? !model_last : pend[1];
                model_last = exp_port;
                model_idle = 1'b0;
                ja = pa[exp_port];
                jb = pb[exp_port];
                in_job = 1'b1;
                age = 0;
            end
            @(posedge clk);
            #1;
            if (free_next) begin
                model_idle = 1'b1;
                free_next  = 1'b0;
            end
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
                checks++;
                if (!in_job || bus.ack1 !== exp_port) begin
                    errors++;
                    $display("FAIL rand_port: got ack on port %0d, required port %0d (job pending=%b)",
                             bus.ack1, exp_port, in_job);
                end
                e = ref_err(ja, jb);
                if (e == 2'b00) begin
                    exp_q = 5'(ja / jb);
                    exp_r = 5'(ja % jb);
                    ok_jobs++;
                end
                checks++;
                if (bus.Q !== exp_q || bus.R !== exp_r || bus.err !== e) begin
                    errors++;
                    $display("FAIL rand_result %0d/%0d: got Q=%0d R=%0d err=%b, required Q=%0d R=%0d err=%b",
                             ja, jb, bus.Q, bus.R, bus.err, exp_q, exp_r, e);
                end
                pend[exp_port] = 1'b0;
                if (exp_port) bus.req1 = 1'b0;
                else          bus.req0 = 1'b0;
                in_job    = 1'b0;
                free_next = 1'b1;
                done++;
            end
            if (in_job) begin
                age++;
                if (age > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_stall: no ack after %0d cycles, required ack within 100", age);
                    break;
                end
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        idle(2);
        checks++;
        if (done != NJOBS) begin
            errors++;
            $display("FAIL rand_jobs: got %0d completed jobs, required %0d", done, NJOBS);
        end
        checks++;
        if (start_cnt - s0 != ok_jobs) begin
            errors++;
            $display("FAIL rand_starts: got %0d div_start pulses, required %0d", start_cnt - s0, ok_jobs);
        end
        checks++;
        if (both_ack_cnt != 0) begin
            errors++;
            $display("FAIL ack_exclusive: got %0d cycles with both acks, required 0", both_ack_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.dividend0 = '0;
        bus.dividend1 = '0;
        bus.divisor0  = '0;
        bus.divisor1  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_div_zero();
        test_overflow();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
